// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 native-interface memory slave.
package picorv32_mem_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CON, S_RESP} state_t;

    typedef enum logic [2:0] {DEC_RAM, DEC_CON, DEC_ERR, DEC_CYC, DEC_BAD} dec_t;

    localparam logic [31:0] CON_TX  = 32'h0000_0000;
    localparam logic [31:0] ERR_CNT = 32'h0000_0004;
    localparam logic [31:0] CYC_CNT = 32'h0000_0008;

    // RAM wins over MMIO; instruction fetches are only legal from RAM.
    function automatic dec_t decode(input logic [29:0] waddr, input logic instr,
                                    input logic [31:0] mmio_base, input logic [31:0] ram_bytes);
        logic [31:0] ba;
        ba = {waddr, 2'b00};
        if (ba < ram_bytes)               return DEC_RAM;
        if (instr)                        return DEC_BAD;
        if (ba == mmio_base + CON_TX)     return DEC_CON;
        if (ba == mmio_base + ERR_CNT)    return DEC_ERR;
        if (ba == mmio_base + CYC_CNT)    return DEC_CYC;
        return DEC_BAD;
    endfunction

endpackage

// File: rtl/picorv32_mem_ram.sv
// Single-port word RAM with per-byte synchronous write and combinational read; never reset.
module picorv32_mem_ram #(
    parameter int MEM_WORDS = 256,
    parameter int AW        = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [3:0]    we_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/picorv32_mem_slave.sv
// picorv32 native-bus memory slave: word RAM plus an MMIO page with console,
// saturating TMR-error counter and free-running cycle counter.
module picorv32_mem_slave
    import picorv32_mem_pkg::*;
#(
    parameter int          MEM_WORDS   = 256,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    output logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic [31:0] mem_rdata,
    input  logic        tmr_error,
    output logic        con_valid,
    input  logic        con_ready,
    output logic [7:0]  con_data,
    output logic        bus_err
);

    localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);
    localparam logic [3:0]  WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [29:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        instr_q;
    logic [31:0] rdata_q;
    logic [7:0]  con_data_q;
    logic        bus_err_q;
    logic [31:0] err_cnt_q;
    logic [31:0] cyc_cnt_q;

    logic [29:0] acc_waddr;
    logic [31:0] acc_wdata;
    logic [3:0]  acc_wstrb;
    logic        acc_instr;
    logic        access;
    dec_t        dec;
    logic        con_wr;
    logic        err_clr;
    logic [3:0]  ram_we;
    logic [31:0] ram_rdata;
    logic [31:0] acc_rdata;
    logic        unused_addr;

    assign unused_addr = &{1'b0, mem_addr[1:0]};

    // With no wait states the access happens in the IDLE cycle, so it must see the live request.
    always_comb begin
        acc_waddr = (state_q == S_IDLE) ? mem_addr[31:2] : addr_q;
        acc_wdata = (state_q == S_IDLE) ? mem_wdata      : wdata_q;
        acc_wstrb = (state_q == S_IDLE) ? mem_wstrb      : wstrb_q;
        acc_instr = (state_q == S_IDLE) ? mem_instr      : instr_q;
        dec       = decode(acc_waddr, acc_instr, MMIO_BASE, RAM_BYTES);
        con_wr    = (dec == DEC_CON) && acc_wstrb[0];
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        access  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_valid && !mem_ready) begin
                    if (WAIT_STATES == 0) begin
                        access  = 1'b1;
                        state_d = con_wr ? S_CON : S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        wcnt_d  = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    access  = 1'b1;
                    state_d = con_wr ? S_CON : S_RESP;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_CON: begin
                if (con_ready) state_d = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ram_we  = (access && !reset && dec == DEC_RAM) ? acc_wstrb : 4'b0000;
        err_clr = access && (dec == DEC_ERR) && (|acc_wstrb);
        case (dec)
            DEC_RAM: acc_rdata = ram_rdata;
            DEC_ERR: acc_rdata = err_cnt_q;
            DEC_CYC: acc_rdata = cyc_cnt_q;
            default: acc_rdata = 32'h0;
        endcase
    end

    picorv32_mem_ram #(
        .MEM_WORDS (MEM_WORDS),
        .AW        (AW)
    ) u_ram (
        .clk     (clk),
        .addr_i  (acc_waddr[AW-1:0]),
        .wdata_i (acc_wdata),
        .we_i    (ram_we),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wcnt_q     <= 4'd0;
            addr_q     <= 30'd0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            instr_q    <= 1'b0;
            rdata_q    <= 32'h0;
            con_data_q <= 8'h0;
            bus_err_q  <= 1'b0;
            err_cnt_q  <= 32'h0;
            cyc_cnt_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            cyc_cnt_q <= cyc_cnt_q + 32'd1;
            if (state_q == S_IDLE && mem_valid && !mem_ready) begin
                addr_q  <= mem_addr[31:2];
                wdata_q <= mem_wdata;
                wstrb_q <= mem_wstrb;
                instr_q <= mem_instr;
            end
            if (access) rdata_q <= acc_rdata;
            if (access && con_wr) con_data_q <= acc_wdata[7:0];
            if (access && dec == DEC_BAD) bus_err_q <= 1'b1;
            // A software clear beats a simultaneous increment.
            if (err_clr) begin
                err_cnt_q <= 32'h0;
            end else if (tmr_error && err_cnt_q != 32'hFFFF_FFFF) begin
                err_cnt_q <= err_cnt_q + 32'd1;
            end
        end
    end

    assign mem_ready = (state_q == S_RESP);
    assign mem_rdata = rdata_q;
    assign con_valid = (state_q == S_CON);
    assign con_data  = con_data_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_picorv32_mem_slave.sv
// Directed bench for picorv32_mem_slave: one instance with no wait states, one with three.
module tb_picorv32_mem_slave;

    localparam logic [31:0] MMIO = 32'h1000_0000;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;
    logic        valid0 = 1'b0, valid1 = 1'b0;
    logic        instr = 1'b0, tmr = 1'b0, con_ready = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;

    logic        ready0, ready1, conv0, conv1, berr0, berr1;
    logic [31:0] rdata0, rdata1;
    logic [7:0]  cond0, cond1;
    logic        ready;
    logic [31:0] rdata;

    assign ready = sel ? ready1 : ready0;
    assign rdata = sel ? rdata1 : rdata0;

    picorv32_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(0), .MMIO_BASE(MMIO)) dut0 (
        .clk(clk), .reset(reset), .mem_valid(valid0), .mem_instr(instr), .mem_ready(ready0),
        .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata0),
        .tmr_error(tmr), .con_valid(conv0), .con_ready(con_ready), .con_data(cond0), .bus_err(berr0)
    );

    picorv32_mem_slave #(.MEM_WORDS(256), .WAIT_STATES(3), .MMIO_BASE(MMIO)) dut1 (
        .clk(clk), .reset(reset), .mem_valid(valid1), .mem_instr(instr), .mem_ready(ready1),
        .mem_addr(addr), .mem_wdata(wdata), .mem_wstrb(wstrb), .mem_rdata(rdata1),
        .tmr_error(tmr), .con_valid(conv1), .con_ready(con_ready), .con_data(cond1), .bus_err(berr1)
    );

    // scoreboard
    int          n_tests = 0;
    int          n_fail = 0;
    int          byte_cnt = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd, c1, c2, c3;

    always @(negedge clk) begin
        if (!reset && conv0 && con_ready) byte_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One core transaction on the selected instance; checks latency, pulse width and,
    // when chk is set, read data against the head of exp_q.
    task automatic bus_xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic ins, input logic chk, output logic [31:0] r);
        int          lat;
        logic [31:0] e;
        addr  = a;
        wdata = d;
        wstrb = s;
        instr = ins;
        if (sel) valid1 = 1'b1; else valid0 = 1'b1;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ready && lat < 40);
        check("latency", 32'(lat), sel ? 32'd4 : 32'd1);
        r      = rdata;
        valid0 = 1'b0;
        valid1 = 1'b0;
        instr  = 1'b0;
        if (chk) begin
            e = exp_q.pop_front();
            check("rdata", r, e);
        end
        tick();
        check("ready_pulse", {31'b0, ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        check("rst_ready", {31'b0, ready0}, 32'd0);
        check("rst_rdata", rdata0, 32'h0);
        check("rst_con_valid", {31'b0, conv0}, 32'd0);
        check("rst_con_data", {24'b0, cond0}, 32'h0);
        check("rst_bus_err", {31'b0, berr0}, 32'd0);
        reset = 1'b0;
        tick();

        // RAM, no wait states
        bus_xfer(32'h3FC, 32'h1234_5678, 4'b1111, 1'b0, 1'b0, rd);
        exp_q.push_back(32'h1234_5678);
        bus_xfer(32'h3FC, 32'h0, 4'b0000, 1'b0, 1'b1, rd);
        exp_q.push_back(32'h1234_5678);
        bus_xfer(32'h3FC, 32'h0000_00AB, 4'b0001, 1'b0, 1'b1, rd);
        exp_q.push_back(32'h1234_56AB);
        bus_xfer(32'h3FC, 32'h0, 4'b0000, 1'b0, 1'b1, rd);
        exp_q.push_back(32'h1234_56AB);
        bus_xfer(32'h3FC, 32'hCAFE_0000, 4'b1100, 1'b0, 1'b1, rd);
        exp_q.push_back(32'hCAFE_56AB);
        bus_xfer(32'h3FE, 32'h0, 4'b0000, 1'b0, 1'b1, rd);

        // console: wstrb[0]=0 is ignored, reads return 0
        con_ready = 1'b1;
        exp_q.push_back(32'h0);
        bus_xfer(MMIO, 32'h42, 4'b0010, 1'b0, 1'b1, rd);
        con_ready = 1'b0;
        check("con_ignored", 32'(byte_cnt), 32'd0);
        exp_q.push_back(32'h0);
        bus_xfer(MMIO, 32'h0, 4'b0000, 1'b0, 1'b1, rd);

        // console write with five stalled cycles
        addr  = MMIO;
        wdata = 32'h0000_0041;
        wstrb = 4'b0001;
        valid0 = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("con_valid_hold", {31'b0, conv0}, 32'd1);
            check("con_data_hold", {24'b0, cond0}, 32'h41);
            check("con_no_ready", {31'b0, ready0}, 32'd0);
            tick();
        end
        con_ready = 1'b1;
        tick();
        check("con_resp_ready", {31'b0, ready0}, 32'd1);
        check("con_valid_drop", {31'b0, conv0}, 32'd0);
        check("con_resp_rdata", rdata0, 32'h0);
        valid0 = 1'b0;
        con_ready = 1'b0;
        tick();
        check("con_ready_pulse", {31'b0, ready0}, 32'd0);
        check("con_bytes", 32'(byte_cnt), 32'd1);

        // TMR error counter
        exp_q.push_back(32'd0);
        bus_xfer(MMIO + 32'h4, 32'h0, 4'b0000, 1'b0, 1'b1, rd);
        tmr = 1'b1;
        repeat (7) tick();
        tmr = 1'b0;
        exp_q.push_back(32'd7);
        bus_xfer(MMIO + 32'h4, 32'h0, 4'b0000, 1'b0, 1'b1, rd);
        addr  = MMIO + 32'h4;
        wdata = 32'h0;
        wstrb = 4'b1111;
        valid0 = 1'b1;
        tmr = 1'b1;
        tick();
        tmr = 1'b0;
        check("clr_ready", {31'b0, ready0}, 32'd1);
        valid0 = 1'b0;
        tick();
        exp_q.push_back(32'd0);
        bus_xfer(MMIO + 32'h4, 32'h0, 4'b0000, 1'b0, 1'b1, rd);

        // cycle counter: accesses are two cycles apart; writes are ignored
        bus_xfer(MMIO + 32'h8, 32'h0, 4'b0000, 1'b0, 1'b0, c1);
        bus_xfer(MMIO + 32'h8, 32'h0, 4'b0000, 1'b0, 1'b0, c2);
        check("cyc_delta", c2 - c1, 32'd2);
        bus_xfer(MMIO + 32'h8, 32'h0, 4'b1111, 1'b0, 1'b0, rd);
        bus_xfer(MMIO + 32'h8, 32'h0, 4'b0000, 1'b0, 1'b0, c3);
        check("cyc_wr_ignored", c3 - c2, 32'd4);

        // decode errors
        check("berr_clear", {31'b0, berr0}, 32'd0);
        bus_xfer(32'h0, 32'h1111_1111, 4'b1111, 1'b0, 1'b0, rd);
        exp_q.push_back(32'h0);
        bus_xfer(32'h400, 32'h5555_5555, 4'b1111, 1'b0, 1'b1, rd);
        check("berr_set", {31'b0, berr0}, 32'd1);
        exp_q.push_back(32'h1111_1111);
        bus_xfer(32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, rd);
        exp_q.push_back(32'h0);
        bus_xfer(32'h2000_0000, 32'h0, 4'b0000, 1'b0, 1'b1, rd);
        exp_q.push_back(32'h0);
        bus_xfer(MMIO + 32'h8, 32'h0, 4'b0000, 1'b1, 1'b1, rd);
        check("berr_sticky", {31'b0, berr0}, 32'd1);

        // three wait states
        sel = 1'b1;
        bus_xfer(32'h0, 32'hA5A5_A5A5, 4'b1111, 1'b0, 1'b0, rd);
        exp_q.push_back(32'hA5A5_A5A5);
        bus_xfer(32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, rd);

        // reset on the access cycle of a WAIT: no write, no response
        addr  = 32'h0;
        wdata = 32'hDEAD_BEEF;
        wstrb = 4'b1111;
        valid1 = 1'b1;
        repeat (3) tick();
        check("wait_no_ready", {31'b0, ready1}, 32'd0);
        reset = 1'b1;
        valid1 = 1'b0;
        tick();
        check("abort_ready", {31'b0, ready1}, 32'd0);
        check("abort_bus_err", {31'b0, berr0}, 32'd0);
        check("abort_rdata", rdata1, 32'h0);
        reset = 1'b0;
        tick();
        exp_q.push_back(32'hA5A5_A5A5);
        bus_xfer(32'h0, 32'h0, 4'b0000, 1'b0, 1'b1, rd);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
